// File: rtl/bi_stream_accum_pkg.sv
// Shared types, defaults and the saturation helper for the bipolar stream accumulator.
package bi_stream_accum_pkg;

    localparam int DEFAULT_WINDOW_LOG2 = 8;
    localparam int DEFAULT_SCALE_LOG2  = 4;
    localparam int DEFAULT_OUT_W       = 14;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                      input int unsigned       w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/bi_win_counter.sv
// Window counter: ones count c and sample count n over 2^WINDOW_LOG2 enabled samples.
module bi_win_counter
    import bi_stream_accum_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   iEn,
    input  logic                   iBit,
    output logic [WINDOW_LOG2:0]   c,
    output logic [WINDOW_LOG2-1:0] n,
    output logic                   last
);

    logic [WINDOW_LOG2:0]   c_reg;
    logic [WINDOW_LOG2-1:0] n_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            c_reg <= '0;
            n_reg <= '0;
        end else if (iEn) begin
            c_reg <= c_reg + {{WINDOW_LOG2{1'b0}}, iBit};
            n_reg <= n_reg + WINDOW_LOG2'(1);
        end
    end

    assign c    = c_reg;
    assign n    = n_reg;
    // Asserted while the sample that completes the window is being taken.
    assign last = iEn && (n_reg == {WINDOW_LOG2{1'b1}});

endmodule

// File: rtl/bi_stream_accum.sv
// Bipolar stochastic stream accumulator with valid/ready result handshake.
// Optional running estimate output oPartial when BI_STREAM_ACCUM_PARTIAL_EN is defined.
module bi_stream_accum
    import bi_stream_accum_pkg::*;
#(
    parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
    parameter int SCALE_LOG2  = DEFAULT_SCALE_LOG2,
    parameter int OUT_W       = DEFAULT_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             iEn,
    input  logic             iBit,
    output logic [OUT_W-1:0] oValue,
    output logic             oValid,
    input  logic             oReady,
    output logic             oBusy
`ifdef BI_STREAM_ACCUM_PARTIAL_EN
    ,
    output logic [OUT_W-1:0] oPartial
`endif
);

    localparam int RAW_W = WINDOW_LOG2 + SCALE_LOG2 + 2;
    localparam logic signed [RAW_W-1:0] WIN_S = RAW_W'(1 << WINDOW_LOG2);

    state_t                   state_reg;
    logic [OUT_W-1:0]         value_reg;
    logic                     valid_reg;
    logic                     busy_reg;

    logic                     cnt_clear;
    logic                     cnt_en;
    logic [WINDOW_LOG2:0]     c_cnt;
    logic [WINDOW_LOG2-1:0]   n_cnt;
    logic                     cnt_last;

    logic [WINDOW_LOG2:0]     c_next;
    logic signed [RAW_W-1:0]  raw_final;
    logic [OUT_W-1:0]         value_next;
    logic                     handshake;

    assign cnt_clear = rst || (state_reg != COUNT);
    assign cnt_en    = iEn && (state_reg == COUNT);
    assign handshake = valid_reg && oReady;

    bi_win_counter #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_win_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .iEn   (cnt_en),
        .iBit  (iBit),
        .c     (c_cnt),
        .n     (n_cnt),
        .last  (cnt_last)
    );

    // The final sample is still in flight when the window closes, so fold it in here.
    assign c_next     = c_cnt + {{WINDOW_LOG2{1'b0}}, iBit};
    assign raw_final  = (signed'(RAW_W'({c_next, 1'b0})) - WIN_S) <<< SCALE_LOG2;
    assign value_next = OUT_W'(sat_signed(32'(raw_final), OUT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            value_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= COUNT;
                        busy_reg  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (cnt_last) begin
                        state_reg <= HOLD;
                        value_reg <= value_next;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        valid_reg <= 1'b0;
                        if (start) begin
                            state_reg <= COUNT;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign oValue = value_reg;
    assign oValid = valid_reg;
    assign oBusy  = busy_reg;

`ifdef BI_STREAM_ACCUM_PARTIAL_EN
    logic [WINDOW_LOG2:0]    n_next;
    logic signed [RAW_W-1:0] raw_partial;
    logic [OUT_W-1:0]        partial_reg;

    assign n_next      = {1'b0, n_cnt} + (WINDOW_LOG2 + 1)'(1);
    assign raw_partial = (signed'(RAW_W'({c_next, 1'b0})) - signed'(RAW_W'(n_next))) <<< SCALE_LOG2;

    always_ff @(posedge clk) begin
        if (rst || (state_reg == IDLE)) begin
            partial_reg <= '0;
        end else if ((state_reg == HOLD) && handshake && start) begin
            partial_reg <= '0;
        end else if (cnt_en) begin
            partial_reg <= OUT_W'(sat_signed(32'(raw_partial), OUT_W));
        end
    end

    assign oPartial = partial_reg;
`else
    logic unused_n;
    assign unused_n = ^n_cnt;
`endif

endmodule

// File: tb/tb_bi_stream_accum.sv
// Scoreboard bench for bi_stream_accum: default instance plus a 12-bit output instance for saturation.
module tb_bi_stream_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        iEn;
    logic        iBit;
    logic        oReady;

    logic [13:0] oValue;
    logic        oValid;
    logic        oBusy;
    logic [11:0] s_value;
    logic        s_valid;
    logic        s_busy;
`ifdef BI_STREAM_ACCUM_PARTIAL_EN
    logic [13:0] oPartial;
    logic [11:0] s_partial;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    bi_stream_accum #(.WINDOW_LOG2(8), .SCALE_LOG2(4), .OUT_W(14)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .iEn    (iEn),
        .iBit   (iBit),
        .oValue (oValue),
        .oValid (oValid),
        .oReady (oReady),
        .oBusy  (oBusy)
`ifdef BI_STREAM_ACCUM_PARTIAL_EN
        ,
        .oPartial (oPartial)
`endif
    );

    bi_stream_accum #(.WINDOW_LOG2(8), .SCALE_LOG2(4), .OUT_W(12)) dut_sat (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .iEn    (iEn),
        .iBit   (iBit),
        .oValue (s_value),
        .oValid (s_valid),
        .oReady (oReady),
        .oBusy  (s_busy)
`ifdef BI_STREAM_ACCUM_PARTIAL_EN
        ,
        .oPartial (s_partial)
`endif
    );

    typedef struct {
        int val;
        int sat;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   presented = 1'b0;

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one scoreboard entry per presented result, checked on its first valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            presented = 1'b0;
        end else if (oValid) begin
            if (!presented) begin
                presented = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency_cycle", cyc, e.cyc);
                    check("value", $signed(oValue), e.val);
                    check("sat_valid", int'(s_valid), 1);
                    check("sat_value", $signed(s_value), e.sat);
                    $display("[TB] result cycle=%0d value=%0d sat=%0d", cyc, $signed(oValue), $signed(s_value));
                end
            end
            if (oReady) presented = 1'b0;
        end
    end

    // mode 0 all ones, 1 all zeros, 2 alternating, 3 first 64 ones then zeros.
    task automatic run_window(input int mode, input bit gaps, input bit do_start,
                              input int exp_val, input int exp_sat);
        int k;
        int ph;
        exp_t e;
        k  = 0;
        ph = 0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("busy_in_count", int'(oBusy), 1);
        while (k < 256) begin
            iEn = !(gaps && (ph % 3 == 2));
            ph++;
            case (mode)
                0: iBit = 1'b1;
                1: iBit = 1'b0;
                2: iBit = k[0];
                default: iBit = (k < 64);
            endcase
            start = (gaps && k == 50);
            tick();
            if (iEn) begin
                k++;
`ifdef BI_STREAM_ACCUM_PARTIAL_EN
                if (mode == 0 && k == 64) begin
                    check("partial_64", $signed(oPartial), 1024);
                    check("sat_partial_64", $signed(s_partial), 1024);
                end
`endif
            end
        end
        iEn   = 1'b0;
        iBit  = 1'b0;
        start = 1'b0;
        e.val = exp_val;
        e.sat = exp_sat;
        e.cyc = cyc;
        exp_q.push_back(e);
        $display("[TB] window mode=%0d gaps=%0d closed cycle=%0d expect=%0d", mode, gaps, cyc, exp_val);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        iEn    = 1'b0;
        iBit   = 1'b0;
        oReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            iEn  = i[0];
            iBit = 1'b1;
            tick();
            check("idle_valid", int'(oValid), 0);
            check("idle_busy", int'(oBusy), 0);
            check("idle_value", $signed(oValue), 0);
        end
        iEn  = 1'b0;
        iBit = 1'b0;

        run_window(0, 1'b0, 1'b1, 4096, 2047);
        tick();
        tick();
        check("after_hs_valid", int'(oValid), 0);
        check("after_hs_busy", int'(oBusy), 0);

        run_window(1, 1'b0, 1'b1, -4096, -2048);
        tick();
        tick();

        run_window(2, 1'b1, 1'b1, 0, 0);
        tick();
        tick();

        oReady = 1'b0;
        run_window(0, 1'b0, 1'b1, 4096, 2047);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            iEn   = 1'b1;
            iBit  = i[0];
            tick();
            check("bp_valid", int'(oValid), 1);
            check("bp_value", $signed(oValue), 4096);
            check("bp_busy", int'(oBusy), 0);
        end
        iEn    = 1'b0;
        oReady = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_valid_drop", int'(oValid), 0);
        run_window(3, 1'b0, 1'b0, -2048, -2048);
        tick();
        tick();

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            iEn  = 1'b1;
            iBit = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", int'(oValid), 0);
        check("rst_mid_busy", int'(oBusy), 0);
        check("rst_mid_value", $signed(oValue), 0);
        check("rst_mid_sat_value", $signed(s_value), 0);
        for (int i = 0; i < 300; i++) begin
            iEn  = 1'b1;
            iBit = 1'b1;
            tick();
        end
        iEn = 1'b0;
        check("rst_idle_busy", int'(oBusy), 0);
        tick();
        tick();

        check("pending_results", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
